// File: rtl/multicycle_sequencer.sv
// Multicycle sequencer for the 4-bit-opcode accumulator ISA; owns PC/IR/MDR and one shared memory port.
// Latency (zero-wait ack): add/load 4, clear 3, store 3, skip/jump/halt/illegal 2 cycles.
// Backpressure: mem_req is held with stable we/addr/wdata until mem_ack; each non-ack cycle adds one cycle.
//
// Ports:
//   clk, reset_n            rising-edge clock, asynchronous active-low reset
//   start                   level-sampled in IDLE only; begins fetching at pc
//   mem_req/we/addr/wdata   shared memory request, decoded from registered state
//   mem_rdata, mem_ack      read data and completion, both sampled in the ack cycle
//   acc_in, acc_zero        accumulator value (store data) and zero flag (skip)
//   acc_we, acc_sel         one-cycle accumulator write strobe: 00 mdr, 01 acc+mdr, 10 clear
//   mdr, pc                 last MEM read data, program counter
//   halted, illegal_op      HALT state flag, one-cycle pulse on decode of opcode 7..15
//   retired                 wrapping count of completed instructions
module multicycle_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 16,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [INSTR_W-1:0] mem_wdata,
    input  logic [INSTR_W-1:0] mem_rdata,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] acc_in,
    input  logic               acc_zero,
    output logic               acc_we,
    output logic [1:0]         acc_sel,
    output logic [INSTR_W-1:0] mdr,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               illegal_op,
    output logic [CNT_W-1:0]   retired
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_HALT  = 4'd1;
    localparam logic [3:0] OP_LOAD  = 4'd2;
    localparam logic [3:0] OP_STORE = 4'd3;
    localparam logic [3:0] OP_CLEAR = 4'd4;
    localparam logic [3:0] OP_SKIP  = 4'd5;
    localparam logic [3:0] OP_JUMP  = 4'd6;

    localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t             state, state_nxt;
    logic [INSTR_W-1:0] ir, ir_nxt;
    logic [INSTR_W-1:0] mdr_nxt;
    logic [ADDR_W-1:0]  pc_nxt;
    logic               retire;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;

    assign opcode  = ir[INSTR_W-1 -: 4];
    assign operand = ir[ADDR_W-1:0];

    // Instruction bits between the opcode and the operand carry no meaning.
    logic unused_ir_bits;
    assign unused_ir_bits = ^ir[INSTR_W-5:ADDR_W];

    // Store data is the live accumulator; it is only qualified by mem_we.
    assign mem_wdata = acc_in;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pc      <= '0;
            ir      <= '0;
            mdr     <= '0;
            retired <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            mdr   <= mdr_nxt;
            if (retire) begin
                retired <= retired + CNT_ONE;
            end
        end
    end

    // Next state plus outputs. All memory and strobe outputs depend only on
    // registered state/ir, so a pending request cannot glitch while waiting.
    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        ir_nxt     = ir;
        mdr_nxt    = mdr;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = pc;
        acc_we     = 1'b0;
        acc_sel    = 2'b00;
        halted     = 1'b0;
        illegal_op = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_nxt    = mem_rdata;
                    pc_nxt    = pc + PC_ONE;
                    state_nxt = S_DECODE;
                end
            end

            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_LOAD, OP_STORE: begin
                        state_nxt = S_MEM;
                    end
                    OP_CLEAR: begin
                        state_nxt = S_WB;
                    end
                    OP_SKIP: begin
                        if (acc_zero) begin
                            pc_nxt = pc + PC_ONE;
                        end
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_JUMP: begin
                        pc_nxt    = operand;
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_HALT: begin
                        retire    = 1'b1;
                        state_nxt = S_HALT;
                    end
                    default: begin
                        // Undefined opcodes retire as NOPs but are flagged.
                        illegal_op = 1'b1;
                        retire     = 1'b1;
                        state_nxt  = S_FETCH;
                    end
                endcase
            end

            S_MEM: begin
                mem_req  = 1'b1;
                mem_addr = operand;
                mem_we   = (opcode == OP_STORE);
                if (mem_ack) begin
                    if (opcode == OP_STORE) begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        mdr_nxt   = mem_rdata;
                        state_nxt = S_WB;
                    end
                end
            end

            S_WB: begin
                acc_we = 1'b1;
                if (opcode == OP_CLEAR) begin
                    acc_sel = 2'b10;
                end else if (opcode == OP_ADD) begin
                    acc_sel = 2'b01;
                end else begin
                    acc_sel = 2'b00;
                end
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end

            S_HALT: begin
                // Terminal: only reset_n leaves this state.
                halted = 1'b1;
            end

            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer with a behavioural memory responder.
// Latency: checks are taken at fixed cycle offsets from the first FETCH cycle.
// Backpressure: responder acks after ack_wait non-ack cycles; returns junk data when not acking.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] acc_in;
    logic        acc_zero;
    logic        acc_we;
    logic [1:0]  acc_sel;
    logic [15:0] mdr;
    logic [7:0]  pc;
    logic        halted;
    logic        illegal_op;
    logic [15:0] retired;

    int errors = 0;
    int checks = 0;

    logic [15:0] mem [0:255];
    logic [3:0]  ack_wait;
    logic [3:0]  wait_cnt = 4'd0;
    int          wr_cnt = 0;
    logic [7:0]  wr_addr = 8'h00;
    logic [15:0] wr_data = 16'h0000;
    int          sel_cnt = 0;
    logic [1:0]  sel_prev = 2'b11;
    logic [1:0]  sel_last = 2'b11;

    multicycle_sequencer #(.ADDR_W(8), .INSTR_W(16), .CNT_W(16)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .start      (start),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .acc_in     (acc_in),
        .acc_zero   (acc_zero),
        .acc_we     (acc_we),
        .acc_sel    (acc_sel),
        .mdr        (mdr),
        .pc         (pc),
        .halted     (halted),
        .illegal_op (illegal_op),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    // Memory responder: junk (opcode 15) when not acking exposes early capture.
    assign mem_ack   = mem_req && (wait_cnt >= ack_wait);
    assign mem_rdata = mem_ack ? mem[mem_addr] : 16'hF0F0;

    always @(posedge clk) begin
        if (mem_req && !mem_ack) wait_cnt <= wait_cnt + 4'd1;
        else                     wait_cnt <= 4'd0;
        if (mem_req && mem_we && mem_ack) begin
            wr_cnt  <= wr_cnt + 1;
            wr_addr <= mem_addr;
            wr_data <= mem_wdata;
        end
        if (acc_we) begin
            sel_cnt  <= sel_cnt + 1;
            sel_prev <= sel_last;
            sel_last <= acc_sel;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] ins(input logic [3:0] op, input logic [7:0] a);
        return {op, 4'h0, a};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        start    = 1'b0;
        ack_wait = 4'd0;
        acc_zero = 1'b0;
        acc_in   = 16'h00AB;
        for (int i = 0; i < 256; i++) mem[i] = ins(4'd1, 8'h00);
        cyc(2);
        reset_n = 1'b1;
        cyc(1);
    endtask

    // Returns at the sample point of cycle 0 (first FETCH cycle).
    task automatic launch();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    int wr0, sel0, ill_hi;

    initial begin
        // ---- reset state ----
        do_reset();
        chk("rst_pc", pc, 0);
        chk("rst_retired", retired, 0);
        chk("rst_mdr", mdr, 0);
        chk("rst_halted", halted, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_acc_we", acc_we, 0);
        chk("rst_illegal", illegal_op, 0);
        cyc(3);
        chk("idle_no_start_req", mem_req, 0);

        // ---- load/add/store/halt program, zero-wait ----
        mem[0]  = ins(4'd2, 8'd10);
        mem[1]  = ins(4'd0, 8'd11);
        mem[2]  = ins(4'd3, 8'd12);
        mem[3]  = ins(4'd1, 8'd0);
        mem[10] = 16'd5;
        mem[11] = 16'd7;
        wr0  = wr_cnt;
        sel0 = sel_cnt;
        launch();
        chk("p1_c0_req", mem_req, 1);
        chk("p1_c0_addr", mem_addr, 0);
        cyc(2);
        chk("p1_c2_load_addr", mem_addr, 10);
        chk("p1_c2_we", mem_we, 0);
        cyc(1);
        chk("p1_c3_acc_we", acc_we, 1);
        chk("p1_c3_sel", acc_sel, 2'b00);
        chk("p1_c3_mdr", mdr, 5);
        cyc(4);
        chk("p1_c7_acc_we", acc_we, 1);
        chk("p1_c7_sel", acc_sel, 2'b01);
        chk("p1_c7_mdr", mdr, 7);
        cyc(3);
        chk("p1_c10_we", mem_we, 1);
        chk("p1_c10_addr", mem_addr, 12);
        chk("p1_c10_wdata", mem_wdata, 16'h00AB);
        cyc(2);
        chk("p1_c12_halted", halted, 0);
        chk("p1_c12_retired", retired, 3);
        cyc(1);
        chk("p1_c13_halted", halted, 1);
        chk("p1_retired", retired, 4);
        chk("p1_pc", pc, 4);
        chk("p1_wr_cnt", wr_cnt - wr0, 1);
        chk("p1_wr_addr", wr_addr, 12);
        chk("p1_wr_data", wr_data, 16'h00AB);
        chk("p1_sel_cnt", sel_cnt - sel0, 2);
        chk("p1_sel_first", sel_prev, 2'b00);
        chk("p1_sel_second", sel_last, 2'b01);
        // start ignored in HALT
        start = 1'b1;
        cyc(3);
        start = 1'b0;
        chk("halt_sticky", halted, 1);
        chk("halt_no_req", mem_req, 0);
        chk("halt_retired", retired, 4);

        // ---- skip at pc=4, acc_zero=1 and 0 ----
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            acc_zero = z[0];
            mem[0] = ins(4'd6, 8'd4);
            mem[4] = ins(4'd5, 8'd0);
            launch();
            cyc(2);
            chk("skip_fetch_at4", mem_addr, 4);
            cyc(2);
            chk("skip_next_req", mem_req, 1);
            chk("skip_next_addr", mem_addr, (z == 1) ? 6 : 5);
            chk("skip_retired", retired, 2);
        end

        // ---- jump 0xFF then skip at 0xFF wraps ----
        do_reset();
        acc_zero = 1'b1;
        mem[0]     = ins(4'd6, 8'hFF);
        mem[8'hFF] = ins(4'd5, 8'd0);
        launch();
        cyc(2);
        chk("wrap_fetch_ff", mem_addr, 8'hFF);
        cyc(1);
        chk("wrap_pc_after_fetch", pc, 8'h00);
        cyc(1);
        chk("wrap_next_addr", mem_addr, 8'h01);
        chk("wrap_pc", pc, 8'h01);

        // ---- FETCH ack delayed 3 cycles ----
        do_reset();
        ack_wait = 4'd3;
        mem[0] = ins(4'd6, 8'h20);
        launch();
        for (int c = 0; c < 4; c++) begin
            chk("dly_req", mem_req, 1);
            chk("dly_addr", mem_addr, 0);
            chk("dly_we", mem_we, 0);
            chk("dly_pc_hold", pc, 0);
            cyc(1);
        end
        chk("dly_decode_no_req", mem_req, 0);
        chk("dly_decode_pc", pc, 1);
        chk("dly_no_illegal", illegal_op, 0);
        cyc(1);
        chk("dly_jump_target", mem_addr, 8'h20);

        // ---- illegal opcode 9 ----
        do_reset();
        mem[0] = 16'h9000;
        launch();
        ill_hi = 0;
        for (int c = 0; c < 4; c++) begin
            if (illegal_op) ill_hi++;
            if (c == 2) begin
                chk("ill_retired", retired, 1);
                chk("ill_next_addr", mem_addr, 1);
                chk("ill_next_req", mem_req, 1);
            end
            cyc(1);
        end
        chk("ill_pulse_cycles", ill_hi, 1);

        // ---- reset during MEM store wait ----
        do_reset();
        ack_wait = 4'd3;
        mem[0] = ins(4'd3, 8'h30);
        wr0 = wr_cnt;
        launch();
        cyc(6);
        chk("rmw_req", mem_req, 1);
        chk("rmw_we", mem_we, 1);
        chk("rmw_addr", mem_addr, 8'h30);
        reset_n = 1'b0;
        #1;
        chk("rmw_req_dropped", mem_req, 0);
        chk("rmw_pc", pc, 0);
        chk("rmw_retired", retired, 0);
        cyc(2);
        reset_n  = 1'b1;
        ack_wait = 4'd0;
        cyc(2);
        chk("rmw_idle_no_req", mem_req, 0);
        chk("rmw_no_write", wr_cnt - wr0, 0);
        launch();
        chk("rmw_refetch_req", mem_req, 1);
        chk("rmw_refetch_addr", mem_addr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
